// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move controller.
// WIN_LINES lists the 8 winning cell triples (rows, columns, diagonals) with row-major cell indices.
package ttt_pkg;

    localparam int N_CELLS = 9;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        COMMIT,
        SETTLE,
        EVAL,
        OVER
    } state_t;

    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/ttt_move_ctrl_if.sv
// Move request handshake between a player source and the move controller.
interface ttt_move_ctrl_if;
    logic       move_valid;
    logic       move_ready;
    logic [3:0] move_idx;

    modport master (output move_valid, output move_idx, input move_ready);
    modport slave  (input move_valid, input move_idx, output move_ready);
endinterface

// File: rtl/ttt_win_check.sv
// Combinational win detector: win is high when any line is fully occupied by sym.
module ttt_win_check
    import ttt_pkg::*;
(
    input  logic [N_CELLS-1:0] cell_valid,
    input  logic [N_CELLS-1:0] cell_symbol,
    input  logic               sym,
    output logic               win
);

    always_comb begin
        win = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (cell_valid[WIN_LINES[l][0]] && cell_valid[WIN_LINES[l][1]] &&
                cell_valid[WIN_LINES[l][2]] &&
                cell_symbol[WIN_LINES[l][0]] == sym &&
                cell_symbol[WIN_LINES[l][1]] == sym &&
                cell_symbol[WIN_LINES[l][2]] == sym)
                win = 1'b1;
        end
    end

endmodule

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller: validates moves, writes the cell registers,
// alternates turns and detects win/draw from the cells' read-back state.
//
// state  | meaning
// CLEAR  | cell_reset held high for CLEAR_CYCLES cycles
// IDLE   | waiting for a move, move_ready=1
// COMMIT | one-cycle cell_set strobe to the latched cell
// SETTLE | cell register updates
// EVAL   | verify the write, count it, check for win/draw
// OVER   | game finished; every move is rejected
module ttt_move_ctrl
    import ttt_pkg::*;
#(
    parameter logic FIRST_SYMBOL = 1'b0,
    parameter int   CLEAR_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               new_game,
    ttt_move_ctrl_if.slave     move,
    input  logic [N_CELLS-1:0] cell_valid,
    input  logic [N_CELLS-1:0] cell_symbol,
    output logic [N_CELLS-1:0] cell_set,
    output logic               cell_set_symbol,
    output logic               cell_reset,
    output logic               turn,
    output logic               move_ok,
    output logic               move_err,
    output logic               game_over,
    output logic               winner_valid,
    output logic               winner,
    output logic [3:0]         move_count
);

    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

    state_t       state;
    logic [CW-1:0] clr_cnt;
    logic [3:0]   idx_q;
    logic         ready_q;
    logic         fire;
    logic         idx_bad;
    logic         win;
    logic [3:0]   cnt_inc;

    assign move.move_ready  = ready_q;
    assign cell_set_symbol  = turn;
    assign fire             = move.move_valid & ready_q;
    assign idx_bad          = (move.move_idx > 4'd8) || cell_valid[move.move_idx];
    assign cnt_inc          = (move_count == 4'd9) ? 4'd9 : move_count + 4'd1;

    // Cells are already updated when EVAL runs, so the check sees the new board.
    ttt_win_check u_win_check (
        .cell_valid  (cell_valid),
        .cell_symbol (cell_symbol),
        .sym         (turn),
        .win         (win)
    );

    always_ff @(posedge clk) begin
        if (!reset_n || new_game) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            idx_q        <= '0;
            cell_reset   <= 1'b1;
            cell_set     <= '0;
            ready_q      <= 1'b0;
            turn         <= FIRST_SYMBOL;
            move_ok      <= 1'b0;
            move_err     <= 1'b0;
            game_over    <= 1'b0;
            winner_valid <= 1'b0;
            winner       <= 1'b0;
            move_count   <= '0;
        end else begin
            move_ok  <= 1'b0;
            move_err <= 1'b0;
            case (state)
                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        cell_reset <= 1'b0;
                        ready_q    <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (fire) begin
                        if (idx_bad) begin
                            move_err <= 1'b1;
                        end else begin
                            idx_q    <= move.move_idx;
                            cell_set <= 9'b1 << move.move_idx;
                            ready_q  <= 1'b0;
                            state    <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    cell_set <= '0;
                    state    <= SETTLE;
                end
                SETTLE: state <= EVAL;
                EVAL: begin
                    ready_q <= 1'b1;
                    if (!cell_valid[idx_q]) begin
                        move_err <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        move_count <= cnt_inc;
                        if (win) begin
                            game_over    <= 1'b1;
                            winner_valid <= 1'b1;
                            winner       <= turn;
                            state        <= OVER;
                        end else if (cnt_inc == 4'd9) begin
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else begin
                            move_ok <= 1'b1;
                            turn    <= ~turn;
                            state   <= IDLE;
                        end
                    end
                end
                OVER: begin
                    if (fire) move_err <= 1'b1;
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Randomized self-checking bench for ttt_move_ctrl with a behavioural board model and cell registers.
module tb_ttt_move_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       new_game = 1'b0;
    logic [8:0] cv = '0;
    logic [8:0] cs = '0;
    logic [8:0] cell_set;
    logic       cell_set_symbol, cell_reset, turn, move_ok, move_err;
    logic       game_over, winner_valid, winner;
    logic [3:0] move_count;
    bit         block_write = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    int board [9];
    bit m_turn, m_over, m_wv, m_w;
    int m_count;

    ttt_move_ctrl_if move_bus ();

    ttt_move_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .new_game        (new_game),
        .move            (move_bus.slave),
        .cell_valid      (cv),
        .cell_symbol     (cs),
        .cell_set        (cell_set),
        .cell_set_symbol (cell_set_symbol),
        .cell_reset      (cell_reset),
        .turn            (turn),
        .move_ok         (move_ok),
        .move_err        (move_err),
        .game_over       (game_over),
        .winner_valid    (winner_valid),
        .winner          (winner),
        .move_count      (move_count)
    );

    always #5 clk = ~clk;

    // The nine cell registers; block_write models a cell that ignores its strobe.
    always @(posedge clk) begin
        if (cell_reset === 1'b1) begin
            cv <= '0;
            cs <= '0;
        end else begin
            for (int i = 0; i < 9; i++)
                if (cell_set[i] === 1'b1 && !block_write) begin
                    cv[i] <= 1'b1;
                    cs[i] <= cell_set_symbol;
                end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_win(bit s);
        bit w = 0;
        int v = int'(s);
        for (int k = 0; k < 3; k++) begin
            if (board[3*k] == v && board[3*k+1] == v && board[3*k+2] == v) w = 1;
            if (board[k] == v && board[k+3] == v && board[k+6] == v) w = 1;
        end
        if (board[0] == v && board[4] == v && board[8] == v) w = 1;
        if (board[2] == v && board[4] == v && board[6] == v) w = 1;
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) board[i] = -1;
        m_turn = 0; m_over = 0; m_wv = 0; m_w = 0; m_count = 0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_turn"},      16'(turn),         16'(m_turn));
        check({tag, "_count"},     16'(move_count),   16'(m_count));
        check({tag, "_game_over"}, 16'(game_over),    16'(m_over));
        check({tag, "_winner_v"},  16'(winner_valid), 16'(m_wv));
        if (m_wv) check({tag, "_winner"}, 16'(winner), 16'(m_w));
    endtask

    task automatic new_game_seq(input bit with_valid);
        new_game = 1'b1;
        move_bus.move_valid = with_valid;
        move_bus.move_idx = 4'($urandom_range(0, 8));
        tick();
        new_game = 1'b0;
        move_bus.move_valid = 1'b0;
        model_reset();
        check("ng_cell_set",   16'(cell_set),            16'(0));
        check("ng_cell_reset", 16'(cell_reset),          16'(1));
        check("ng_ready",      16'(move_bus.move_ready), 16'(0));
        check("ng_err",        16'(move_err),            16'(0));
        check_status("ng");
        tick();
        check("clr_hold",      16'(cell_reset),          16'(1));
        tick();
        check("clr_done",      16'(cell_reset),          16'(0));
        check("clr_ready",     16'(move_bus.move_ready), 16'(1));
    endtask

    task automatic do_move(input int idx, input bit blk);
        bit         legal;
        logic [8:0] exp_set;
        legal = !m_over && idx <= 8 && board[idx] < 0;
        check("pre_ready", 16'(move_bus.move_ready), 16'(1));
        block_write = blk;
        move_bus.move_valid = 1'b1;
        move_bus.move_idx = 4'(idx);
        tick();
        if (!legal) begin
            move_bus.move_valid = 1'b0;
            check("rej_err",   16'(move_err),            16'(1));
            check("rej_set",   16'(cell_set),            16'(0));
            check("rej_ok",    16'(move_ok),             16'(0));
            check("rej_ready", 16'(move_bus.move_ready), 16'(1));
            check_status("rej");
        end else begin
            // Requests while move_ready is low must be ignored.
            move_bus.move_valid = 1'($urandom_range(0, 1));
            move_bus.move_idx = 4'($urandom_range(0, 15));
            exp_set = 9'b1 << idx;
            check("c1_set",   16'(cell_set),            16'(exp_set));
            check("c1_sym",   16'(cell_set_symbol),     16'(m_turn));
            check("c1_ready", 16'(move_bus.move_ready), 16'(0));
            check("c1_err",   16'(move_err),            16'(0));
            tick();
            check("c2_set",   16'(cell_set),            16'(0));
            tick();
            check("c3_ready", 16'(move_bus.move_ready), 16'(0));
            tick();
            move_bus.move_valid = 1'b0;
            if (blk) begin
                check("c4_err", 16'(move_err), 16'(1));
                check("c4_ok",  16'(move_ok),  16'(0));
            end else begin
                board[idx] = int'(m_turn);
                if (m_count < 9) m_count++;
                if (model_win(m_turn)) begin
                    m_over = 1; m_wv = 1; m_w = m_turn;
                    check("c4_ok", 16'(move_ok), 16'(0));
                end else if (m_count == 9) begin
                    m_over = 1;
                    check("c4_ok", 16'(move_ok), 16'(0));
                end else begin
                    check("c4_ok", 16'(move_ok), 16'(1));
                    m_turn = !m_turn;
                end
                check("c4_err", 16'(move_err), 16'(0));
            end
            check("c4_ready", 16'(move_bus.move_ready), 16'(1));
            check_status("c4");
        end
        block_write = 1'b0;
        tick();
        check("pulse_ok_low",  16'(move_ok),  16'(0));
        check("pulse_err_low", 16'(move_err), 16'(0));
    endtask

    int seq_win  [5] = '{0, 3, 1, 4, 2};
    int seq_draw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    initial begin
        move_bus.move_valid = 1'b0;
        move_bus.move_idx = '0;
        model_reset();

        reset_n = 1'b0;
        tick();
        tick();
        check("rst_cell_reset", 16'(cell_reset),          16'(1));
        check("rst_ready",      16'(move_bus.move_ready), 16'(0));
        check("rst_set",        16'(cell_set),            16'(0));
        check_status("rst");
        reset_n = 1'b1;
        tick();
        check("rst_clr_hold", 16'(cell_reset), 16'(1));
        tick();
        check("rst_clr_done", 16'(cell_reset),          16'(0));
        check("rst_idle_rdy", 16'(move_bus.move_ready), 16'(1));
        check_status("idle");

        do_move(4, 0);
        do_move(4, 0);
        do_move(9, 0);
        do_move(15, 0);

        new_game_seq(1);
        foreach (seq_win[i]) do_move(seq_win[i], 0);
        check("win_over", 16'(game_over), 16'(1));
        do_move(8, 0);

        new_game_seq(0);
        foreach (seq_draw[i]) do_move(seq_draw[i], 0);
        check("draw_over", 16'(winner_valid), 16'(0));
        do_move(0, 0);

        new_game_seq(0);
        do_move(2, 1);
        move_bus.move_valid = 1'b1;
        move_bus.move_idx = 4'd0;
        tick();
        move_bus.move_valid = 1'b0;
        check("abort_c1_set", 16'(cell_set), 16'(9'h001));
        new_game_seq(0);

        for (int g = 0; g < 15; g++) begin
            new_game_seq(1'($urandom_range(0, 1)));
            for (int k = 0; k < 40 && !m_over; k++)
                do_move(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15))
                                                    : int'($urandom_range(0, 8)),
                        ($urandom_range(0, 9) == 0));
            if (m_over) do_move(int'($urandom_range(0, 8)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
